// File: rtl/dp_pkg.sv
// Shared datapath definitions: add/sub opcode encoding and the result flag bundle.
package dp_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
    } flags_t;

endpackage

// File: rtl/add_slice.sv
// One pipeline stage of pipe_add: sums slice IDX of the operands with the incoming carry and
// registers the whole operand/partial-sum word so later stages can continue the addition.
module add_slice
    import dp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 8,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] sum_acc,
    input  logic             cin,
    output logic [WIDTH-1:0] sum_next,
    output logic             carry_next,
    output logic             valid_reg,
    output logic [WIDTH-1:0] a_reg,
    output logic [WIDTH-1:0] b_reg,
    output logic [WIDTH-1:0] sum_reg,
    output logic             carry_reg
);

    localparam int LO = IDX * CHUNK;

    logic [CHUNK:0] part;

    assign part = {1'b0, a[LO +: CHUNK]} + {1'b0, b[LO +: CHUNK]} + {{CHUNK{1'b0}}, cin};

    // Lower slices already hold their sums; this stage fills in its own slice.
    always_comb begin
        sum_next               = sum_acc;
        sum_next[LO +: CHUNK]  = part[CHUNK-1:0];
    end

    assign carry_next = part[CHUNK];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
        end else if (en) begin
            valid_reg <= valid;
            if (valid) begin
                a_reg     <= a;
                b_reg     <= b;
                sum_reg   <= sum_next;
                carry_reg <= carry_next;
            end
        end
    end

endmodule

// File: rtl/pipe_add.sv
// Pipelined add/subtract unit, STAGES cycles of latency, valid/ready on both sides.
// Define PIPE_ADD_SAT_EN to clamp overflowing results to the signed max/min.
module pipe_add
    import dp_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int CHUNK = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    generate
        if ((WIDTH < 2) || (STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_param_check
            $error("pipe_add: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
        end
    endgenerate

    logic                          adv;
    logic [STAGES-1:0]             v_src;
    logic [STAGES-1:0]             v_reg;
    logic [STAGES-1:0]             c_src;
    logic [STAGES-1:0]             c_reg;
    logic [STAGES-1:0]             c_next;
    logic [STAGES-1:0][WIDTH-1:0]  a_src;
    logic [STAGES-1:0][WIDTH-1:0]  b_src;
    logic [STAGES-1:0][WIDTH-1:0]  s_src;
    logic [STAGES-1:0][WIDTH-1:0]  a_reg;
    logic [STAGES-1:0][WIDTH-1:0]  b_reg;
    logic [STAGES-1:0][WIDTH-1:0]  s_reg;
    logic [STAGES-1:0][WIDTH-1:0]  s_next;

    // Whole pipeline moves in lockstep; any backpressure freezes every stage.
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = v_reg[LAST];

    // Subtraction is A + ~B + 1.
    assign a_src[0] = in1;
    assign b_src[0] = (op == OP_SUB) ? ~in2 : in2;
    assign c_src[0] = (op == OP_SUB);
    assign s_src[0] = '0;
    assign v_src[0] = in_valid;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi > 0) begin : g_link
                assign a_src[gi] = a_reg[gi-1];
                assign b_src[gi] = b_reg[gi-1];
                assign s_src[gi] = s_reg[gi-1];
                assign c_src[gi] = c_reg[gi-1];
                assign v_src[gi] = v_reg[gi-1];
            end

            add_slice #(
                .WIDTH (WIDTH),
                .CHUNK (CHUNK),
                .IDX   (gi)
            ) u_slice (
                .clk        (clk),
                .rst_n      (rst_n),
                .en         (adv),
                .valid      (v_src[gi]),
                .a          (a_src[gi]),
                .b          (b_src[gi]),
                .sum_acc    (s_src[gi]),
                .cin        (c_src[gi]),
                .sum_next   (s_next[gi]),
                .carry_next (c_next[gi]),
                .valid_reg  (v_reg[gi]),
                .a_reg      (a_reg[gi]),
                .b_reg      (b_reg[gi]),
                .sum_reg    (s_reg[gi]),
                .carry_reg  (c_reg[gi])
            );
        end
    endgenerate

    logic [WIDTH-1:0] raw_sum;
    logic [WIDTH-1:0] res_next;
    logic             a_msb;
    logic             b_msb;
    logic             ovf_next;
    flags_t           flags_next;
    flags_t           flags_reg;
    logic [WIDTH-1:0] out_reg;

    assign raw_sum  = s_next[LAST];
    assign a_msb    = a_src[LAST][WIDTH-1];
    assign b_msb    = b_src[LAST][WIDTH-1];
    assign ovf_next = (a_msb == b_msb) && (raw_sum[WIDTH-1] != a_msb);

`ifdef PIPE_ADD_SAT_EN
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    // Overflow direction follows A's sign: positive A can only overflow upward.
    assign res_next = ovf_next ? (a_msb ? SMIN : SMAX) : raw_sum;
`else
    assign res_next = raw_sum;
`endif

    always_comb begin
        flags_next.cout = c_next[LAST];
        flags_next.ovf  = ovf_next;
        flags_next.zero = (res_next == '0);
    end

    // Result and flags only move when a real result enters the last stage, so bubbles keep them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_reg   <= '0;
            flags_reg <= '0;
        end else if (adv && v_src[LAST]) begin
            out_reg   <= res_next;
            flags_reg <= flags_next;
        end
    end

    assign out  = out_reg;
    assign cout = flags_reg.cout;
    assign ovf  = flags_reg.ovf;
    assign zero = flags_reg.zero;

    // The last stage's operand/sum registers are superseded by out_reg/flags_reg.
    logic unused_bits;
    assign unused_bits = ^{a_reg[LAST], b_reg[LAST], s_reg[LAST], c_reg[LAST], s_next, c_next};

endmodule

// File: tb/tb_pipe_add.sv
// Directed and randomised checks of pipe_add (STAGES=2 directed, STAGES=1 and 4 randomised).
module tb_pipe_add;

`ifdef PIPE_ADD_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, op, out_valid, out_ready, cout, ovf, zero;
    logic [15:0] in1, in2, out;

    logic [1:0]       r_in_valid, r_in_ready, r_op, r_out_valid, r_out_ready, r_cout, r_ovf, r_zero;
    logic [1:0][15:0] r_in1, r_in2, r_out;

    int checks   = 0;
    int failures = 0;

    pipe_add #(.WIDTH(16), .STAGES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .cout(cout), .ovf(ovf), .zero(zero)
    );

    pipe_add #(.WIDTH(16), .STAGES(1)) u_dut_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(r_in_valid[0]), .in_ready(r_in_ready[0]), .op(r_op[0]),
        .in1(r_in1[0]), .in2(r_in2[0]), .out_valid(r_out_valid[0]), .out_ready(r_out_ready[0]),
        .out(r_out[0]), .cout(r_cout[0]), .ovf(r_ovf[0]), .zero(r_zero[0])
    );

    pipe_add #(.WIDTH(16), .STAGES(4)) u_dut_s4 (
        .clk(clk), .rst_n(rst_n), .in_valid(r_in_valid[1]), .in_ready(r_in_ready[1]), .op(r_op[1]),
        .in1(r_in1[1]), .in2(r_in2[1]), .out_valid(r_out_valid[1]), .out_ready(r_out_ready[1]),
        .out(r_out[1]), .cout(r_cout[1]), .ovf(r_ovf[1]), .zero(r_zero[1])
    );

    typedef struct {
        logic        op;
        logic [15:0] a, b, ow, os;
        logic        c, v, zw, zs;
    } vec_t;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: {cout, ovf, zero, out} from integer arithmetic.
    function automatic logic [18:0] ref_model(input logic opx, input logic [15:0] a, input logic [15:0] b);
        int          sa, sb, res;
        logic [15:0] r;
        logic        c, v;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (opx) begin
            r   = a - b;
            c   = (a >= b);
            res = sa - sb;
        end else begin
            {c, r} = {1'b0, a} + {1'b0, b};
            res    = sa + sb;
        end
        v = (res > 32767) || (res < -32768);
        if (SAT && v) r = (res > 32767) ? 16'h7FFF : 16'h8000;
        return {c, v, (r == 16'h0000), r};
    endfunction

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(7))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'hFFFF;
            3:       return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; op = 1'b0; in1 = '0; in2 = '0; out_ready = 1'b1;
        r_in_valid = '0; r_op = '0; r_in1 = '0; r_in2 = '0; r_out_ready = '1;
        #2;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_handshake: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        checks++;
        if ({out, cout, ovf, zero} !== 19'h0) begin
            failures++;
            $display("FAIL reset_outputs: out=%h c/o/z=%b%b%b required 0000/000", out, cout, ovf, zero);
        end
        checks++;
        if (r_out_valid !== 2'b00) begin
            failures++;
            $display("FAIL reset_aux_valid: got %b required 00", r_out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        $display("reset: out_valid=%b in_ready=%b out=%h", out_valid, in_ready, out);
    endtask

    task automatic test_arith;
        vec_t        v [8];
        logic [15:0] exp_out;
        logic        exp_zero;
        v[0] = '{1'b0, 16'h00FF, 16'h0001, 16'h0100, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0};
        v[1] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1};
        v[2] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0};
        v[3] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0};
        v[4] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b0};
        v[5] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 16'h8000, 1'b1, 1'b1, 1'b1, 1'b0};
        v[6] = '{1'b1, 16'h1234, 16'h1234, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1};
        v[7] = '{1'b1, 16'h7FFF, 16'hFFFF, 16'h8000, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_out  = SAT ? v[i].os : v[i].ow;
            exp_zero = SAT ? v[i].zs : v[i].zw;
            in_valid = 1'b1; op = v[i].op; in1 = v[i].a; in2 = v[i].b;
            tick();
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL arith%0d_latency: out_valid=%b after 1 cycle required 0", i, out_valid);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out !== exp_out) begin
                failures++;
                $display("FAIL arith%0d_out: valid=%b out=%h required 1/%h", i, out_valid, out, exp_out);
            end
            checks++;
            if ({cout, ovf, zero} !== {v[i].c, v[i].v, exp_zero}) begin
                failures++;
                $display("FAIL arith%0d_flags: c/o/z=%b%b%b required %b%b%b", i, cout, ovf, zero,
                         v[i].c, v[i].v, exp_zero);
            end
            $display("arith%0d: op=%b %h,%h -> out=%h c=%b o=%b z=%b", i, v[i].op, v[i].a, v[i].b, out, cout, ovf, zero);
            tick();
            checks++;
            if (out_valid !== 1'b0 || out !== exp_out || {cout, ovf, zero} !== {v[i].c, v[i].v, exp_zero}) begin
                failures++;
                $display("FAIL arith%0d_bubble_hold: valid=%b out=%h required 0/%h with flags held", i, out_valid, out, exp_out);
            end
        end
    endtask

    task automatic test_back_to_back;
        int          acc = 0;
        int          pops = 0;
        logic [15:0] held = '0;
        bit          stalled = 1'b0;
        for (int c = 0; c < 16; c++) begin
            out_ready = !(c >= 2 && c <= 5);
            if (acc < 4) begin
                in_valid = 1'b1; op = 1'b0; in1 = 16'(acc + 1); in2 = 16'(acc + 1);
            end else begin
                in_valid = 1'b0;
            end
            #3;
            if (stalled) begin
                checks++;
                if (out !== held || out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_stall_hold: cycle %0d valid=%b out=%h required 1/%h", c, out_valid, out, held);
                end
            end
            if (out_valid && !out_ready) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_in_ready_full: cycle %0d in_ready=%b required 0", c, in_ready);
                end
                held = out; stalled = 1'b1;
            end else begin
                stalled = 1'b0;
            end
            if (!out_valid) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_in_ready_empty: cycle %0d in_ready=%b required 1", c, in_ready);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (out !== 16'(2 * (pops + 1))) begin
                    failures++;
                    $display("FAIL b2b_order: pop %0d out=%h required %h", pops, out, 16'(2 * (pops + 1)));
                end
                $display("b2b: cycle %0d pop %0d out=%h", c, pops, out);
                pops++;
            end
            if (in_valid && in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (pops != 4) begin
            failures++;
            $display("FAIL b2b_count: popped %0d required 4", pops);
        end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        in_valid = 1'b1; op = 1'b0; in1 = 16'h1111; in2 = 16'h2222;
        tick();
        in1 = 16'h0101; in2 = 16'h0101;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out !== 16'h3333) begin
            failures++;
            $display("FAIL rstmid_pre: valid=%b out=%h required 1/3333", out_valid, out);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || {out, cout, ovf, zero} !== 19'h0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_async: valid=%b out=%h flags=%b%b%b in_ready=%b required 0/0000/000/1",
                     out_valid, out, cout, ovf, zero, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_flushed: valid=%b required 0", out_valid);
        end
        in_valid = 1'b1; op = 1'b0; in1 = 16'h0003; in2 = 16'h0004;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_latency: valid=%b after 1 cycle required 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out !== 16'h0007) begin
            failures++;
            $display("FAIL rstmid_new_op: valid=%b out=%h required 1/0007", out_valid, out);
        end
        $display("rstmid: new op out=%h valid=%b", out, out_valid);
        tick();
    endtask

    task automatic test_random(input int sel, input int n);
        logic [18:0] q[$];
        logic [18:0] got, exp_v;
        int          issued = 0;
        int          popped = 0;
        int          cyc = 0;
        bit          accepted;
        r_in_valid[sel] = 1'b0;
        while (popped < n && cyc < 2000) begin
            if (!r_in_valid[sel] && issued < n && $urandom_range(3) != 0) begin
                r_in_valid[sel] = 1'b1;
                r_op[sel]       = 1'($urandom_range(1));
                r_in1[sel]      = pick_operand();
                r_in2[sel]      = pick_operand();
            end
            r_out_ready[sel] = ($urandom_range(3) != 0);
            #3;
            accepted = 1'b0;
            if (r_in_valid[sel] && r_in_ready[sel]) begin
                q.push_back(ref_model(r_op[sel], r_in1[sel], r_in2[sel]));
                issued++;
                accepted = 1'b1;
            end
            if (r_out_valid[sel] && r_out_ready[sel]) begin
                got = {r_cout[sel], r_ovf[sel], r_zero[sel], r_out[sel]};
                exp_v = (q.size() > 0) ? q.pop_front() : 19'h7FFFF;
                checks++;
                if (got !== exp_v) begin
                    failures++;
                    $display("FAIL rand_s%0d_pop%0d: c/o/z/out=%h required %h", (sel == 0) ? 1 : 4, popped, got, exp_v);
                end
                $display("rand_s%0d: pop %0d c/o/z/out=%h", (sel == 0) ? 1 : 4, popped, got);
                popped++;
            end
            tick();
            if (accepted) r_in_valid[sel] = 1'b0;
            cyc++;
        end
        r_in_valid[sel] = 1'b0;
        checks++;
        if (popped != n) begin
            failures++;
            $display("FAIL rand_s%0d_timeout: popped %0d of %0d", (sel == 0) ? 1 : 4, popped, n);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_back_to_back();
        test_reset_mid();
        test_random(0, 40);
        test_random(1, 40);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
